// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the two-requester adder scheduler.
package add_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/add_sched_if.sv
// Requester, result and status bundle of the adder scheduler.
interface add_sched_if
  import add_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             a_valid;
  logic             b_valid;
  logic [WIDTH-1:0] a_op0;
  logic [WIDTH-1:0] a_op1;
  logic [WIDTH-1:0] b_op0;
  logic [WIDTH-1:0] b_op1;
  logic             a_ready;
  logic             b_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;
  logic [CNT_W-1:0] op_count;

  modport master (
    output a_valid, b_valid, a_op0, a_op1, b_op0, b_op1, res_ready,
    input  a_ready, b_ready, res_valid, res_sum, res_carry, res_id, op_count
  );

  modport slave (
    input  a_valid, b_valid, a_op0, a_op1, b_op0, b_op1, res_ready,
    output a_ready, b_ready, res_valid, res_sum, res_carry, res_id, op_count
  );

endinterface

// File: rtl/add_sched_core.sv
// Result-slot FSM, shared adder and accept counter, seen through the bus modport.
module add_sched_core
  import add_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  add_sched_if.slave bus
);

  state_t           state;
  req_id_t          last_grant;
  req_id_t          sel;
  logic             slot_free;
  logic             accept;
  logic [1:0]       grant;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] op1;
  logic [WIDTH:0]   sum_full;

  assign slot_free = (state == EMPTY) || bus.res_ready;

  rr_arb2 u_arb (
    .valid     ({bus.b_valid, bus.a_valid}),
    .last      (last_grant),
    .slot_free (slot_free),
    .grant     (grant)
  );

  // Reset masks the grant so nothing is accepted while rst is high.
  assign bus.a_ready = grant[0] & ~rst;
  assign bus.b_ready = grant[1] & ~rst;
  assign accept      = (grant != 2'b00);

  assign sel      = grant[1] ? ID_B : ID_A;
  assign op0      = (sel == ID_B) ? bus.b_op0 : bus.a_op0;
  assign op1      = (sel == ID_B) ? bus.b_op1 : bus.a_op1;
  assign sum_full = {1'b0, op0} + {1'b0, op1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      last_grant    <= ID_B;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_carry <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.op_count  <= '0;
    end else if (accept) begin
      state         <= FULL;
      last_grant    <= sel;
      bus.res_valid <= 1'b1;
      bus.res_sum   <= sum_full[WIDTH-1:0];
      bus.res_carry <= sum_full[WIDTH];
      bus.res_id    <= sel;
      bus.op_count  <= bus.op_count + CNT_W'(1);
    end else if (state == FULL && bus.res_ready) begin
      state         <= EMPTY;
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/add_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
module rr_arb2
  import add_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  input  logic       slot_free,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (slot_free) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last == ID_B) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/add_sched.sv
// Adder scheduler top: flat ports mapped onto the internal bus for the core.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] a_op0,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] b_op0,
  input  logic [WIDTH-1:0] b_op1,
  output logic             a_ready,
  output logic             b_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic [CNT_W-1:0] op_count
);

  add_sched_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  assign bus.a_valid   = a_valid;
  assign bus.b_valid   = b_valid;
  assign bus.a_op0     = a_op0;
  assign bus.a_op1     = a_op1;
  assign bus.b_op0     = b_op0;
  assign bus.b_op1     = b_op1;
  assign bus.res_ready = res_ready;

  assign a_ready   = bus.a_ready;
  assign b_ready   = bus.b_ready;
  assign res_valid = bus.res_valid;
  assign res_sum   = bus.res_sum;
  assign res_carry = bus.res_carry;
  assign res_id    = bus.res_id;
  assign op_count  = bus.op_count;

  add_sched_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-operation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports a_valid, b_valid  input  1 each  requester A/B operation pending.
REQ-006 SHALL have ports a_op0, a_op1, b_op0, b_op1  input  WIDTH each  operand pairs of A and B.
REQ-007 SHALL have ports a_ready, b_ready  output  1 each  requester operation accepted this cycle.
REQ-008 SHALL have port res_valid  output  1  result register holds an undelivered sum.
REQ-009 SHALL have port res_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port res_sum  output  WIDTH  sum modulo 2^WIDTH.
REQ-011 SHALL have port res_carry  output  1  carry-out bit WIDTH of the full sum.
REQ-012 SHALL have port res_id  output  1  source of the result: 0 = A, 1 = B.
REQ-013 SHALL have port op_count  output  CNT_W  number of accepted operations.

Function
REQ-014 SHALL share one WIDTH-bit adder between A and B; op0 + op1 computed at WIDTH+1 bits, low WIDTH to res_sum, MSB to res_carry.
REQ-015 SHALL implement a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 SHALL define slot_free = (state==EMPTY) or res_ready.
REQ-017 SHALL assert at most one of a_ready/b_ready per cycle, only while slot_free and that requester's valid is high.
REQ-018 SHALL grant the sole valid requester when only one is valid.
REQ-019 SHALL, when both are valid, grant the requester not granted most recently; last-grant pointer resets to B, so A wins the first tie.
REQ-020 SHALL update the last-grant pointer only on an accepted operation.
REQ-021 SHALL, on accept (x_valid and x_ready at edge N), load res_sum/res_carry/res_id from that requester at edge N; res_valid high in cycle N+1 (latency 1).
REQ-022 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on res_ready with no accept; FULL->FULL on res_ready with accept (back-to-back, one result per cycle).
REQ-023 SHALL hold res_sum, res_carry, res_id stable while res_valid=1 and res_ready=0.
REQ-024 SHALL ignore res_ready in EMPTY.
REQ-025 SHALL derive ready from valid and state only; requesters hold valid and operands until accepted; ready may fall only after acceptance.
REQ-026 SHALL increment op_count by 1 per accepted operation, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-027 SHALL, while rst=1, force state EMPTY, res_valid=0, res_sum=0, res_carry=0, res_id=0, op_count=0, last-grant=B, a_ready=b_ready=0, asynchronously.
REQ-028 SHALL discard an in-flight undelivered result when rst asserts mid-operation; no acceptance on the edge where rst is high.
REQ-029 SHALL resume accepting on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL place the FSM state type (EMPTY, FULL), requester-id encoding (ID_A=0, ID_B=1) and default WIDTH/CNT_W constants in package add_sched_pkg.
REQ-031 SHALL implement the two-requester round-robin grant (inputs: valids, pointer, slot_free; outputs: one-hot grant) as sub-module rr_arb2.
REQ-032 SHALL instantiate exactly one adder; no per-requester adders.

Verification
REQ-033 SHALL cover: A only, a_op0=0x12, a_op1=0x34, res_ready=1 -> next cycle res_valid=1, res_sum=0x46, res_carry=0, res_id=0, op_count=1.
REQ-034 SHALL cover: B only, b_op0=0xFF, b_op1=0x01 -> res_sum=0x00, res_carry=1, res_id=1.
REQ-035 SHALL cover: A and B valid continuously 6 cycles after reset, res_ready=1 -> grants A,B,A,B,A,B; res_id 0,1,0,1,0,1 one cycle later; op_count=6.
REQ-036 SHALL cover: FULL with res_ready=0 for 3 cycles, A valid -> a_ready=0, result unchanged; res_ready=1 -> result delivered and A accepted same cycle.
REQ-037 SHALL cover: rst pulse while FULL with res_sum=0x46 -> immediately res_valid=0, res_sum=0, op_count=0; after release a tie grants A first.
REQ-038 SHALL cover: CNT_W=4, 17 accepted operations -> op_count wraps to 1.
